// File: rtl/debounce_sync.sv
// Two-to-four flop synchronizer followed by a stability-counter debouncer with rise/fall strobes.
// Optional saturating accepted-rise counter enabled by DEBOUNCE_SYNC_EDGE_COUNT_EN.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  output logic             q,
  output logic             rise_pulse,
  output logic             fall_pulse,
`ifdef DEBOUNCE_SYNC_EDGE_COUNT_EN
  input  logic             clear_count,
  output logic [CNT_W-1:0] edge_count,
`endif
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Elaboration-time guards on the legal parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("debounce_sync: DEBOUNCE_CYCLES must be 2..65535");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("debounce_sync: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_sync;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  // Pure shift chain: nothing between the synchronizer flops.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  assign d_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (d_sync) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!d_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!d_sync) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (d_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
    // busy is registered from the next state so it tracks the state register exactly.
    busy_d = (state_d == S_RISE) || (state_d == S_FALL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q          = q_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

`ifdef DEBOUNCE_SYNC_EDGE_COUNT_EN
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Counts cycles with rise_pulse high; saturates, and clear wins over increment.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (clear_count) begin
      edge_cnt_d = '0;
    end else if (rise_q && (edge_cnt_q != {CNT_W{1'b1}})) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_count = edge_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync at SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (CNT_W=2 for the edge counter).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_debounce_sync;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_in = 1'b0;
  logic q, rise_pulse, fall_pulse, busy;
`ifdef DEBOUNCE_SYNC_EDGE_COUNT_EN
  logic clear_count = 1'b0;
  logic [CNT_W-1:0] edge_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d_in(d_in),
    .q(q),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
`ifdef DEBOUNCE_SYNC_EDGE_COUNT_EN
    .clear_count(clear_count),
    .edge_count(edge_count),
`endif
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-edge outputs after a level change is first captured at edge 0.
  task automatic test_reset();
    reset = 1'b1;
    d_in  = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      n_chk++;
      if ({q, rise_pulse, fall_pulse, busy} !== 4'b0000)
        $display("FAIL reset edge %0d: q/rise/fall/busy=%b expected 0000", e, {q, rise_pulse, fall_pulse, busy});
      else n_pass++;
    end
  endtask

  task automatic test_rise();
    logic [6:0] exp_busy = 7'b0011100;  // bit e = after edge e
    logic [6:0] exp_q    = 7'b1100000;
    logic [6:0] exp_rise = 7'b0100000;
    reset = 1'b0;
    d_in  = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      n_chk++;
      if ({q, rise_pulse, fall_pulse, busy} !== {exp_q[e], exp_rise[e], 1'b0, exp_busy[e]})
        $display("FAIL rise edge %0d: q/rise/fall/busy=%b expected %b", e,
                 {q, rise_pulse, fall_pulse, busy}, {exp_q[e], exp_rise[e], 1'b0, exp_busy[e]});
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [9:0] exp_busy = 10'b0000011100;
    for (int e = 0; e < 10; e++) begin
      d_in = (e < 3) ? 1'b0 : 1'b1;
      tick();
      n_chk++;
      if ({q, rise_pulse, fall_pulse, busy} !== {1'b1, 1'b0, 1'b0, exp_busy[e]})
        $display("FAIL glitch edge %0d: q/rise/fall/busy=%b expected %b", e,
                 {q, rise_pulse, fall_pulse, busy}, {1'b1, 1'b0, 1'b0, exp_busy[e]});
      else n_pass++;
    end
  endtask

  task automatic test_fall();
    logic [7:0] exp_busy = 8'b00011100;
    logic [7:0] exp_q    = 8'b00011111;
    logic [7:0] exp_fall = 8'b00100000;
    d_in = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_chk++;
      if ({q, rise_pulse, fall_pulse, busy} !== {exp_q[e], 1'b0, exp_fall[e], exp_busy[e]})
        $display("FAIL fall edge %0d: q/rise/fall/busy=%b expected %b", e,
                 {q, rise_pulse, fall_pulse, busy}, {exp_q[e], 1'b0, exp_fall[e], exp_busy[e]});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_rise();
    // q=0 here; four edges with d_in=1 put the FSM in S_RISE with cnt=2.
    d_in = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    n_chk++;
    if ({q, busy} !== 2'b01)
      $display("FAIL mid_rise_pre: q/busy=%b expected 01", {q, busy});
    else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++;
    if ({q, rise_pulse, fall_pulse, busy} !== 4'b0000)
      $display("FAIL mid_rise_reset: q/rise/fall/busy=%b expected 0000", {q, rise_pulse, fall_pulse, busy});
    else n_pass++;
    test_rise();
  endtask

  task automatic test_reset_while_high();
    // q=1 from the previous rise; reset must drop q silently.
    reset = 1'b1;
    tick();
    n_chk++;
    if ({q, rise_pulse, fall_pulse, busy} !== 4'b0000)
      $display("FAIL reset_high: q/rise/fall/busy=%b expected 0000", {q, rise_pulse, fall_pulse, busy});
    else n_pass++;
    d_in = 1'b0;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) tick();
  endtask

`ifdef DEBOUNCE_SYNC_EDGE_COUNT_EN
  task automatic do_rise_fall(input int idx, input logic [CNT_W-1:0] exp_cnt);
    d_in = 1'b1;
    for (int e = 0; e < 6; e++) tick();
    n_chk++;
    if (rise_pulse !== 1'b1)
      $display("FAIL edge_count rise %0d: rise_pulse=%b expected 1", idx, rise_pulse);
    else n_pass++;
    tick();
    n_chk++;
    if (edge_count !== exp_cnt)
      $display("FAIL edge_count %0d: got %0d expected %0d", idx, edge_count, exp_cnt);
    else n_pass++;
    d_in = 1'b0;
    for (int e = 0; e < 8; e++) tick();
  endtask

  task automatic test_edge_count();
    logic [CNT_W-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1;
    d_in  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_chk++;
    if (edge_count !== '0)
      $display("FAIL edge_count reset: got %0d expected 0", edge_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) do_rise_fall(i, exp_seq[i]);
    // Clear asserted in the cycle rise_pulse is high: clear must win.
    d_in = 1'b1;
    for (int e = 0; e < 6; e++) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    n_chk++;
    if (edge_count !== '0)
      $display("FAIL edge_count clear: got %0d expected 0", edge_count);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_reset_mid_rise();
    test_reset_while_high();
`ifdef DEBOUNCE_SYNC_EDGE_COUNT_EN
    test_edge_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
